nl_act_scheduler: RTL and testbench
===================================

Name: nl_act_scheduler

Overview:
- Job-level controller in front of the nonlinear activation unit (ReLU / sigmoid / tanh).
- Accepts activation jobs over a valid/ready interface.
- Loads the coefficient LUT for sigmoid or tanh from the configuration memory, but only when the table resident in the LUT belongs to another function.
- Then launches the activation unit, tracks completion through its drain, and reports done or error per job.

Parameters:
- LUT_ADDR, 7, LUT write-address width
- LUT_DATA_WIDTH, 8, LUT word width
- CFG_ADDR_W, 12, configuration-memory address width
- SIG_BASE, 0, first LUT index of the sigmoid table
- SIG_LEN, 53, sigmoid table length in words
- TANH_BASE, 53, first LUT index of the tanh table
- TANH_LEN, 53, tanh table length in words
- N_DIM_ARRAY, 8, words per activation step; job length must be a multiple of this
- DRAIN_CYCLES, 2, cycles waited after finished_activation before the job retires

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-low reset
- job_valid  in  1  job request
- job_ready  out  1  scheduler can accept a job
- job_type  in  3  0=ReLU, 3=sigmoid, 4=tanh
- job_cycles  in  16  total activation words
- job_shift  in  8  fixed-point shift
- job_cfg_base  in  CFG_ADDR_W  config-memory address of LUT word 0 of the table
- lut_invalidate  in  1  forces a reload on the next sigmoid/tanh job
- job_done  out  1  one-cycle pulse on successful completion
- job_err  out  1  one-cycle pulse on rejected job
- cfg_rd_en  out  1  config-memory read strobe
- cfg_rd_addr  out  CFG_ADDR_W  config-memory read address
- cfg_rd_data  in  LUT_DATA_WIDTH  read data, valid one cycle after cfg_rd_en
- wr_en_ext_lut  out  1  LUT write strobe
- wr_addr_ext_lut  out  LUT_ADDR  LUT write address
- wr_data_ext_lut  out  LUT_DATA_WIDTH  LUT write data (signed)
- enable_nonlinear_block  out  1  one-cycle launch pulse
- type_nonlinear_function  out  3  registered job type
- NUMBER_OF_ACTIVATION_CYCLES  out  16  registered job length
- SHIFT_FIXED_POINT  out  8  registered shift
- finished_activation  in  1  completion flag from the activation unit
- busy  out  1  high in every state except IDLE

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low.
  - Reset values: state=IDLE, job_ready=1, all strobes/pulses 0, all addresses/data 0, registered job fields 0, resident-table tag=NONE.
  - Reset mid-operation aborts immediately. No done or err is produced, and the tag returns to NONE.
- Acceptance: a job is accepted on the clock edge where job_valid & job_ready.
  - job_ready = (state==IDLE).
  - job_type, job_cycles and job_shift are captured into the three registered outputs, which stay stable until the next accept.
- Validation in the accept cycle. A job is rejected if:
  - job_type is not in {0,3,4}, or
  - job_cycles==0, or
  - job_cycles is not a multiple of N_DIM_ARRAY.
- Rejected job: state goes to ERR. job_err pulses the next cycle, then the block returns to IDLE. No LUT write, no launch.
- States and transitions:
  - IDLE -> LOAD when the job is valid, is sigmoid/tanh, and the tag differs from its type (or lut_invalidate is pending).
  - IDLE -> LAUNCH otherwise (ReLU, or the table is already resident).
  - LOAD issues reads k=0..L-1, one per cycle:
    - cfg_rd_addr = job_cfg_base (captured) + k.
    - The write for word k occurs in the following cycle, with wr_addr_ext_lut = BASE+k and wr_data_ext_lut = cfg_rd_data.
    - LOAD lasts L+1 cycles, where the last cycle is the write of word L-1. L and BASE come from SIG_* or TANH_*.
    - After the final write the tag is set to the job type, and the state moves to LAUNCH.
  - LAUNCH: enable_nonlinear_block=1 for exactly one cycle, then RUN.
  - RUN: finished_activation is ignored in the first RUN cycle, because the activation unit's counter is still 0. The state moves to DRAIN on the first later cycle with finished_activation=1.
  - DRAIN: counts DRAIN_CYCLES cycles, then DONE.
  - DONE: job_done=1 for one cycle, then IDLE.
- lut_invalidate:
  - Sets a sticky pending flag in any state.
  - The flag clears, and the tag becomes NONE, when the next LOAD begins.
  - If lut_invalidate is asserted during LOAD, the load completes but the tag is left at NONE.
- Back-to-back jobs: job_ready rises the cycle after DONE, so the minimum job-to-job spacing is 1 idle cycle.
- Latency, ReLU with job_cycles=8, counted from the accept edge:
  - launch pulse at cycle 1;
  - done pulse at 1 + RUN cycles + DRAIN_CYCLES + 1.

Test Plan:
- Sigmoid job (type 3, cycles 16, cfg_base 0x100) after reset -> 53 cfg reads at 0x100..0x134; LUT writes to 0..52 carrying the returned data one cycle later; one enable pulse; job_done once, 2 cycles after finished_activation is seen.
- Second sigmoid job -> no cfg_rd_en, launch one cycle after accept. Then a tanh job -> 53 writes to LUT 53..105.
- ReLU job (type 0, cycles 8) -> no LUT traffic; type_nonlinear_function=0, NUMBER_OF_ACTIVATION_CYCLES=8 held from accept through done.
- Invalid jobs: type 2; cycles 0; cycles 12 with N_DIM_ARRAY=8 -> job_err pulse each, no enable, no LUT write, tag unchanged.
- lut_invalidate asserted during RUN of a sigmoid job, followed by another sigmoid job -> full reload occurs.
- reset deasserted-to-low during LOAD at word 20 -> all outputs to reset values; next sigmoid job reloads all 53 words.

Source files
------------

// File: rtl/nl_act_scheduler.sv
// nl_act_scheduler
// Job-level controller in front of the nonlinear activation unit.
// Accepts one activation job at a time and validates it. For sigmoid/tanh
// jobs it streams the coefficient table from configuration memory into the
// LUT, but only when the resident table belongs to another function. It then
// launches the activation unit, waits for completion plus a drain period, and
// reports done or err.
//
// Ports
//   clk, reset               clock, asynchronous active-low reset
//   job_valid/job_ready      job handshake; ready only while IDLE
//   job_type/cycles/shift    job descriptor (0=ReLU, 3=sigmoid, 4=tanh)
//   job_cfg_base             config address of word 0 of the table to load
//   lut_invalidate           forces a reload on the next sigmoid/tanh job
//   job_done, job_err        one-cycle completion / rejection pulses
//   cfg_rd_*                 config-memory read port (data one cycle later)
//   *_ext_lut                LUT write port
//   enable_nonlinear_block   one-cycle launch pulse
//   type_nonlinear_function, NUMBER_OF_ACTIVATION_CYCLES, SHIFT_FIXED_POINT
//                            job fields held from accept to the next accept
//   finished_activation      completion flag from the activation unit
//   busy                     high whenever not IDLE
module nl_act_scheduler #(
   parameter int LUT_ADDR       = 7,
   parameter int LUT_DATA_WIDTH = 8,
   parameter int CFG_ADDR_W     = 12,
   parameter int SIG_BASE       = 0,
   parameter int SIG_LEN        = 53,
   parameter int TANH_BASE      = 53,
   parameter int TANH_LEN       = 53,
   parameter int N_DIM_ARRAY    = 8,
   parameter int DRAIN_CYCLES   = 2
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      job_valid,
   output logic                      job_ready,
   input  logic [2:0]                job_type,
   input  logic [15:0]               job_cycles,
   input  logic [7:0]                job_shift,
   input  logic [CFG_ADDR_W-1:0]     job_cfg_base,
   input  logic                      lut_invalidate,
   output logic                      job_done,
   output logic                      job_err,
   output logic                      cfg_rd_en,
   output logic [CFG_ADDR_W-1:0]     cfg_rd_addr,
   input  logic [LUT_DATA_WIDTH-1:0] cfg_rd_data,
   output logic                      wr_en_ext_lut,
   output logic [LUT_ADDR-1:0]       wr_addr_ext_lut,
   output logic [LUT_DATA_WIDTH-1:0] wr_data_ext_lut,
   output logic                      enable_nonlinear_block,
   output logic [2:0]                type_nonlinear_function,
   output logic [15:0]               NUMBER_OF_ACTIVATION_CYCLES,
   output logic [7:0]                SHIFT_FIXED_POINT,
   input  logic                      finished_activation,
   output logic                      busy
);

   // Counter is one bit wider than the LUT address so it can reach L itself.
   localparam int CNT_W = LUT_ADDR + 1;
   localparam logic [CNT_W-1:0]    SIG_LEN_C    = CNT_W'(SIG_LEN);
   localparam logic [CNT_W-1:0]    TANH_LEN_C   = CNT_W'(TANH_LEN);
   localparam logic [LUT_ADDR-1:0] SIG_BASE_C   = LUT_ADDR'(SIG_BASE);
   localparam logic [LUT_ADDR-1:0] TANH_BASE_C  = LUT_ADDR'(TANH_BASE);
   localparam logic [CNT_W-1:0]    DRAIN_LAST_C = CNT_W'(DRAIN_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_LAUNCH, S_RUN, S_DRAIN, S_DONE, S_ERR
   } state_t;

   typedef enum logic [1:0] {TAG_NONE, TAG_SIG, TAG_TANH} tag_t;

   state_t                  state_q;
   tag_t                    tag_q;
   logic                    pend_q;
   logic                    runFirst_q;
   logic [CNT_W-1:0]        cnt_q;
   logic [CFG_ADDR_W-1:0]   cfgBase_q;
   logic                    rdEn_q;
   logic [CFG_ADDR_W-1:0]   rdAddr_q;
   logic                    wrEn_q;
   logic [LUT_ADDR-1:0]     wrAddr_q;
   logic                    launch_q;
   logic                    done_q;
   logic                    err_q;
   logic [2:0]              type_q;
   logic [15:0]             cycles_q;
   logic [7:0]              shift_q;

   logic                    typeOk;
   logic                    cyclesOk;
   logic                    isLutJob;
   tag_t                    jobTag;
   logic                    needLoad;
   logic [CNT_W-1:0]        curLen;
   logic [LUT_ADDR-1:0]     curBase;
   tag_t                    curTag;

   // Decode of the incoming job, used only in the accept cycle. A pending
   // invalidate (or one arriving right now) forces the reload.
   assign typeOk   = (job_type == 3'd0) || (job_type == 3'd3) || (job_type == 3'd4);
   assign cyclesOk = (job_cycles != 16'd0) &&
                     ((job_cycles % 16'(N_DIM_ARRAY)) == 16'd0);
   assign isLutJob = (job_type == 3'd3) || (job_type == 3'd4);
   assign jobTag   = (job_type == 3'd3) ? TAG_SIG : TAG_TANH;
   assign needLoad = isLutJob && ((tag_q != jobTag) || pend_q || lut_invalidate);

   // Table geometry of the captured job, used while loading.
   assign curLen  = (type_q == 3'd3) ? SIG_LEN_C  : TANH_LEN_C;
   assign curBase = (type_q == 3'd3) ? SIG_BASE_C : TANH_BASE_C;
   assign curTag  = (type_q == 3'd3) ? TAG_SIG    : TAG_TANH;

   // Job sequencer. Pulse outputs default low each cycle and are raised on
   // the edge that enters the state they belong to, so each one is visible
   // exactly during that state's cycle. In LOAD, cnt_q is the index of the
   // current cycle: read k is issued in cycle k and written in cycle k+1.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         tag_q      <= TAG_NONE;
         pend_q     <= 1'b0;
         runFirst_q <= 1'b0;
         cnt_q      <= '0;
         cfgBase_q  <= '0;
         rdEn_q     <= 1'b0;
         rdAddr_q   <= '0;
         wrEn_q     <= 1'b0;
         wrAddr_q   <= '0;
         launch_q   <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         type_q     <= '0;
         cycles_q   <= '0;
         shift_q    <= '0;
      end else begin
         launch_q <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         rdEn_q   <= 1'b0;
         wrEn_q   <= 1'b0;
         if (lut_invalidate) begin
            pend_q <= 1'b1;
         end
         case (state_q)
            S_IDLE: begin
               if (job_valid) begin
                  type_q   <= job_type;
                  cycles_q <= job_cycles;
                  shift_q  <= job_shift;
                  if (!(typeOk && cyclesOk)) begin
                     state_q <= S_ERR;
                     err_q   <= 1'b1;
                  end else if (needLoad) begin
                     state_q   <= S_LOAD;
                     cnt_q     <= '0;
                     cfgBase_q <= job_cfg_base;
                     rdEn_q    <= 1'b1;
                     rdAddr_q  <= job_cfg_base;
                     tag_q     <= TAG_NONE;
                     pend_q    <= 1'b0;
                  end else begin
                     state_q  <= S_LAUNCH;
                     launch_q <= 1'b1;
                  end
               end
            end
            S_LOAD: begin
               if (cnt_q == curLen) begin
                  // Last write is out; an invalidate seen during the load
                  // leaves the table untrusted.
                  state_q  <= S_LAUNCH;
                  launch_q <= 1'b1;
                  tag_q    <= (pend_q || lut_invalidate) ? TAG_NONE : curTag;
               end else begin
                  wrEn_q   <= 1'b1;
                  wrAddr_q <= curBase + cnt_q[LUT_ADDR-1:0];
                  if ((cnt_q + 1'b1) < curLen) begin
                     rdEn_q   <= 1'b1;
                     rdAddr_q <= cfgBase_q + CFG_ADDR_W'(cnt_q + 1'b1);
                  end
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            S_LAUNCH: begin
               state_q    <= S_RUN;
               runFirst_q <= 1'b1;
            end
            S_RUN: begin
               // The unit's counter is still zero in the first RUN cycle, so
               // its finished flag is stale there.
               if (runFirst_q) begin
                  runFirst_q <= 1'b0;
               end else if (finished_activation) begin
                  state_q <= S_DRAIN;
                  cnt_q   <= '0;
               end
            end
            S_DRAIN: begin
               if (cnt_q == DRAIN_LAST_C) begin
                  state_q <= S_DONE;
                  done_q  <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            S_DONE:  state_q <= S_IDLE;
            S_ERR:   state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign job_ready                   = (state_q == S_IDLE);
   assign busy                        = (state_q != S_IDLE);
   assign job_done                    = done_q;
   assign job_err                     = err_q;
   assign cfg_rd_en                   = rdEn_q;
   assign cfg_rd_addr                 = rdAddr_q;
   assign wr_en_ext_lut               = wrEn_q;
   assign wr_addr_ext_lut             = wrAddr_q;
   // Read data is only valid in the write cycle, so it is forwarded directly.
   assign wr_data_ext_lut             = wrEn_q ? cfg_rd_data : '0;
   assign enable_nonlinear_block      = launch_q;
   assign type_nonlinear_function     = type_q;
   assign NUMBER_OF_ACTIVATION_CYCLES = cycles_q;
   assign SHIFT_FIXED_POINT           = shift_q;

endmodule

// File: tb/tb_nl_act_scheduler.sv
// tb_nl_act_scheduler
// Randomized bench for nl_act_scheduler. The job driver predicts every
// config read, LUT write, launch and result from the block's rules (resident
// table tag, pending invalidate) and queues them. An independent monitor pops
// and compares whenever the DUT presents one of those events. A small
// activation-unit model raises finished_activation a random delay after each
// launch and queues the expected done cycle.
module tb_nl_act_scheduler;

   localparam int SIG_BASE  = 0;
   localparam int SIG_LEN   = 53;
   localparam int TANH_BASE = 53;
   localparam int TANH_LEN  = 53;
   localparam int DRAIN     = 2;

   logic        clk;
   logic        reset;
   logic        job_valid;
   logic        job_ready;
   logic [2:0]  job_type;
   logic [15:0] job_cycles;
   logic [7:0]  job_shift;
   logic [11:0] job_cfg_base;
   logic        lut_invalidate;
   logic        job_done;
   logic        job_err;
   logic        cfg_rd_en;
   logic [11:0] cfg_rd_addr;
   logic [7:0]  cfg_rd_data;
   logic        wr_en_ext_lut;
   logic [6:0]  wr_addr_ext_lut;
   logic [7:0]  wr_data_ext_lut;
   logic        enable_nonlinear_block;
   logic [2:0]  type_nonlinear_function;
   logic [15:0] NUMBER_OF_ACTIVATION_CYCLES;
   logic [7:0]  SHIFT_FIXED_POINT;
   logic        finished_activation;
   logic        busy;

   nl_act_scheduler dut (
      .clk                         (clk),
      .reset                       (reset),
      .job_valid                   (job_valid),
      .job_ready                   (job_ready),
      .job_type                    (job_type),
      .job_cycles                  (job_cycles),
      .job_shift                   (job_shift),
      .job_cfg_base                (job_cfg_base),
      .lut_invalidate              (lut_invalidate),
      .job_done                    (job_done),
      .job_err                     (job_err),
      .cfg_rd_en                   (cfg_rd_en),
      .cfg_rd_addr                 (cfg_rd_addr),
      .cfg_rd_data                 (cfg_rd_data),
      .wr_en_ext_lut               (wr_en_ext_lut),
      .wr_addr_ext_lut             (wr_addr_ext_lut),
      .wr_data_ext_lut             (wr_data_ext_lut),
      .enable_nonlinear_block      (enable_nonlinear_block),
      .type_nonlinear_function     (type_nonlinear_function),
      .NUMBER_OF_ACTIVATION_CYCLES (NUMBER_OF_ACTIVATION_CYCLES),
      .SHIFT_FIXED_POINT           (SHIFT_FIXED_POINT),
      .finished_activation         (finished_activation),
      .busy                        (busy)
   );

   typedef struct {
      int cyc;
      int typ;
      int len;
      int shift;
   } launch_t;

   typedef struct {
      bit isErr;
      int cyc;
      int typ;
      int len;
      int shift;
   } res_t;

   logic [7:0] cfgMem [0:4095];
   int         expRd[$];
   int         expWr[$];
   launch_t    expLaunch[$];
   res_t       expRes[$];
   int         expDone[$];
   int         checks = 0;
   int         errors = 0;
   int         cyc = 0;
   int         tagM = 0;
   bit         pendM = 0;
   int         finAt = -1;
   int         finDelay;
   launch_t    monL;
   res_t       monR;
   int         monW;
   int         monD;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Configuration memory: answers one cycle after a read strobe and returns
   // junk otherwise, so a mistimed LUT write shows up as bad data.
   always @(posedge clk) begin
      if (cfg_rd_en) cfg_rd_data <= cfgMem[cfg_rd_addr];
      else           cfg_rd_data <= 8'($urandom);
   end

   task automatic checkOutput(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic failEvent(input string name, input int act);
      checks++;
      errors++;
      $display("[TB] FAIL %s: got %0d with nothing expected (cycle %0d)", name, act, cyc);
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, "_job_ready"}, job_ready, 1);
      checkOutput({tag, "_busy"}, busy, 0);
      checkOutput({tag, "_cfg_rd_en"}, cfg_rd_en, 0);
      checkOutput({tag, "_cfg_rd_addr"}, cfg_rd_addr, 0);
      checkOutput({tag, "_wr_en"}, wr_en_ext_lut, 0);
      checkOutput({tag, "_wr_addr"}, wr_addr_ext_lut, 0);
      checkOutput({tag, "_wr_data"}, wr_data_ext_lut, 0);
      checkOutput({tag, "_enable"}, enable_nonlinear_block, 0);
      checkOutput({tag, "_type"}, type_nonlinear_function, 0);
      checkOutput({tag, "_ncycles"}, NUMBER_OF_ACTIVATION_CYCLES, 0);
      checkOutput({tag, "_shift"}, SHIFT_FIXED_POINT, 0);
      checkOutput({tag, "_done"}, job_done, 0);
      checkOutput({tag, "_err"}, job_err, 0);
   endtask

   // Activation-unit model: finished goes high d cycles into RUN and stays
   // high until the next launch. A flag in the first RUN cycle is ignored, so
   // retirement happens max(d,1) cycles into RUN, then DRAIN, then DONE.
   always @(negedge clk) begin
      if (reset === 1'b1) begin
         if (enable_nonlinear_block) begin
            finDelay = int'($urandom_range(0, 4));
            finished_activation = 1'b0;
            finAt = cyc + 1 + finDelay;
            expDone.push_back(cyc + 1 + ((finDelay < 1) ? 1 : finDelay) + DRAIN + 1);
         end else if (cyc == finAt) begin
            finished_activation = 1'b1;
         end
      end
   end

   // Monitor: every strobe/pulse the DUT presents must match the head of its
   // expectation queue.
   always @(negedge clk) begin
      if (reset === 1'b1) begin
         if (cfg_rd_en) begin
            if (expRd.size() == 0) failEvent("cfg_rd_unexpected", cfg_rd_addr);
            else checkOutput("cfg_rd_addr", cfg_rd_addr, expRd.pop_front());
         end
         if (wr_en_ext_lut) begin
            if (expWr.size() == 0) failEvent("lut_wr_unexpected", wr_addr_ext_lut);
            else begin
               monW = expWr.pop_front();
               checkOutput("lut_wr_addr", wr_addr_ext_lut, monW >> 8);
               checkOutput("lut_wr_data", wr_data_ext_lut, monW & 255);
            end
         end
         if (enable_nonlinear_block) begin
            if (expLaunch.size() == 0) failEvent("launch_unexpected", cyc);
            else begin
               monL = expLaunch.pop_front();
               checkOutput("launch_cycle", cyc, monL.cyc);
               checkOutput("launch_type", type_nonlinear_function, monL.typ);
               checkOutput("launch_ncycles", NUMBER_OF_ACTIVATION_CYCLES, monL.len);
               checkOutput("launch_shift", SHIFT_FIXED_POINT, monL.shift);
            end
         end
         if (job_done || job_err) begin
            if (expRes.size() == 0) failEvent("result_unexpected", {job_err, job_done});
            else begin
               monR = expRes.pop_front();
               checkOutput("result_kind", int'({job_err, job_done}), monR.isErr ? 2 : 1);
               if (monR.isErr) checkOutput("err_cycle", cyc, monR.cyc);
               else if (expDone.size() == 0) failEvent("done_without_launch", cyc);
               else begin
                  monD = expDone.pop_front();
                  checkOutput("done_cycle", cyc, monD);
               end
               checkOutput("result_type", type_nonlinear_function, monR.typ);
               checkOutput("result_ncycles", NUMBER_OF_ACTIVATION_CYCLES, monR.len);
               checkOutput("result_shift", SHIFT_FIXED_POINT, monR.shift);
            end
         end
      end
   end

   // Reference model for one job accepted at cycle a: returns whether a
   // table load happens and queues reads, writes, launch and result.
   task automatic predictJob(input int typ, input int len, input int shift,
                             input int base, input int a, input bit withResult,
                             output bit doLoad, output int tblLen);
      bit valid;
      int tblBase;
      launch_t l;
      res_t r;
      valid   = (typ == 0 || typ == 3 || typ == 4) && len != 0 && (len % 8) == 0;
      doLoad  = valid && typ != 0 && (tagM != typ || pendM);
      tblLen  = (typ == 3) ? SIG_LEN : TANH_LEN;
      tblBase = (typ == 3) ? SIG_BASE : TANH_BASE;
      if (doLoad) begin
         for (int k = 0; k < tblLen; k++) begin
            expRd.push_back(base + k);
            expWr.push_back(((tblBase + k) << 8) | int'(cfgMem[base + k]));
         end
         pendM = 0;
         tagM  = typ;
      end
      r.isErr = !valid;
      r.cyc   = a;
      r.typ   = typ;
      r.len   = len;
      r.shift = shift;
      if (valid) begin
         l.cyc   = doLoad ? a + tblLen + 1 : a;
         l.typ   = typ;
         l.len   = len;
         l.shift = shift;
         expLaunch.push_back(l);
      end
      if (withResult) expRes.push_back(r);
   endtask

   // Issues one job in the first IDLE cycle and waits for its result.
   // invOff >= 0 pulses lut_invalidate invOff cycles after the accept edge.
   task automatic applyStimulus(input int typ, input int len, input int shift,
                                input int base, input int invOff);
      int n = 0;
      int a;
      int tblLen;
      bit doLoad;
      bit gotRes = 0;
      @(negedge clk);
      while (!job_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!job_ready) begin
         failEvent("ready_timeout", cyc);
         return;
      end
      a = cyc + 1;
      predictJob(typ, len, shift, base, a, 1'b1, doLoad, tblLen);
      if (invOff >= 0) begin
         pendM = 1;
         if (doLoad && invOff <= tblLen) tagM = 0;
      end
      job_valid    = 1'b1;
      job_type     = 3'(typ);
      job_cycles   = 16'(len);
      job_shift    = 8'(shift);
      job_cfg_base = 12'(base);
      n = 0;
      while ((!gotRes || (invOff >= 0 && cyc <= a + invOff)) && n < 400) begin
         @(negedge clk);
         n++;
         if (n == 1) begin
            // Scramble the inputs so the held job fields must come from capture.
            job_valid    = 1'b0;
            job_type     = 3'($urandom);
            job_cycles   = 16'($urandom);
            job_shift    = 8'($urandom);
            job_cfg_base = 12'($urandom);
         end
         lut_invalidate = (invOff >= 0 && cyc == a + invOff);
         if (job_done || job_err) gotRes = 1;
      end
      lut_invalidate = 1'b0;
      if (!gotRes) failEvent("result_timeout", cyc);
   endtask

   // Starts a table-loading sigmoid job and pulls reset low in the cycle
   // where read 20 is issued; everything must return to its reset value and
   // the tag must be forgotten.
   task automatic resetDuringLoad(input int base);
      int n = 0;
      int a;
      int tblLen;
      bit doLoad;
      @(negedge clk);
      while (!job_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      a = cyc + 1;
      predictJob(3, 16, 9, base, a, 1'b0, doLoad, tblLen);
      job_valid    = 1'b1;
      job_type     = 3'd3;
      job_cycles   = 16'd16;
      job_shift    = 8'd9;
      job_cfg_base = 12'(base);
      @(negedge clk);
      job_valid = 1'b0;
      n = 0;
      while (cyc < a + 20 && n < 100) begin
         @(negedge clk);
         n++;
      end
      checkOutput("pre_reset_cfg_rd_addr", cfg_rd_addr, base + 20);
      #2;
      reset = 1'b0;
      #1;
      checkResetValues("midload_reset");
      expRd.delete();
      expWr.delete();
      expLaunch.delete();
      expRes.delete();
      tagM  = 0;
      pendM = 0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
   endtask

   initial begin
      int typTab[10] = '{0, 3, 4, 3, 4, 2, 5, 7, 0, 3};
      int r;
      int len;
      for (int i = 0; i < 4096; i++) cfgMem[i] = 8'($urandom);
      reset               = 1'b0;
      job_valid           = 1'b0;
      job_type            = '0;
      job_cycles          = '0;
      job_shift           = '0;
      job_cfg_base        = '0;
      lut_invalidate      = 1'b0;
      finished_activation = 1'b0;
      repeat (3) @(negedge clk);
      checkResetValues("reset");
      reset = 1'b1;

      // Directed sequence
      applyStimulus(3, 16, 5, 'h100, -1);   // first sigmoid: full load
      applyStimulus(3, 32, 3, 'h500, -1);   // sigmoid resident: no load
      applyStimulus(4, 8, 1, 'h300, -1);    // tanh: load into 53..105
      applyStimulus(0, 8, 7, 'h000, -1);    // ReLU: never touches the LUT
      applyStimulus(2, 8, 0, 'h000, -1);    // bad type
      applyStimulus(4, 0, 0, 'h000, -1);    // zero length
      applyStimulus(4, 12, 0, 'h000, -1);   // not a multiple of 8
      applyStimulus(4, 16, 4, 'h300, -1);   // tag survived the rejects
      applyStimulus(3, 8, 2, 'h100, -1);    // back to sigmoid: load
      applyStimulus(3, 8, 2, 'h100, 1);     // invalidate in first RUN cycle
      applyStimulus(3, 8, 2, 'h100, -1);    // must reload
      applyStimulus(4, 8, 6, 'h040, 10);    // invalidate during LOAD
      applyStimulus(4, 8, 6, 'h040, -1);    // tag was left NONE: reload
      resetDuringLoad('h100);
      applyStimulus(3, 16, 8, 'h100, -1);   // full reload after abort

      // Randomized jobs
      for (int j = 0; j < 25; j++) begin
         r = int'($urandom_range(0, 9));
         if (r == 0)      len = 0;
         else if (r == 1) len = 12;
         else             len = 8 * int'($urandom_range(1, 8));
         applyStimulus(typTab[$urandom_range(0, 9)], len,
                       int'($urandom_range(0, 255)),
                       int'($urandom_range(0, 4000)),
                       ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 60)) : -1);
      end

      repeat (4) @(negedge clk);
      checkOutput("leftover_reads", expRd.size(), 0);
      checkOutput("leftover_writes", expWr.size(), 0);
      checkOutput("leftover_launches", expLaunch.size(), 0);
      checkOutput("leftover_results", expRes.size(), 0);
      checkOutput("idle_ready", job_ready, 1);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #600000;
      errors++;
      $display("[TB] FAIL watchdog: simulation still running at cycle %0d", cyc);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
